// File: rtl/peak_result_serializer.sv
// rtl/peak_result_serializer.sv - double-buffered serializer of per-pixel peak results into a ready/valid beat stream
module peak_result_serializer #(
    parameter int NP        = 16,
    parameter int PIXEL_NUM = 4
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    frame_done,
    input  logic [NP*PIXEL_NUM-1:0] result,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NP-1:0]           out_data,
    output logic [7:0]              out_pix,
    output logic [7:0]              out_frame,
    output logic                    out_last,
    output logic                    overflow,
    input  logic                    clr_ovf
);

    localparam int         BW       = NP * PIXEL_NUM;
    localparam logic [7:0] LAST_PIX = 8'(PIXEL_NUM - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] act_q, act_d;
    logic [BW-1:0] shd_q, shd_d;
    logic [7:0]    act_tag_q, act_tag_d;
    logic [7:0]    shd_tag_q, shd_tag_d;
    logic          pending_q, pending_d;
    logic [7:0]    pix_q, pix_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          xfer;
    logic          last_xfer;
    logic          ovf_set;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= IDLE;
            act_q     <= '0;
            shd_q     <= '0;
            act_tag_q <= '0;
            shd_tag_q <= '0;
            pending_q <= 1'b0;
            pix_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            act_tag_q <= act_tag_d;
            shd_tag_q <= shd_tag_d;
            pending_q <= pending_d;
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        shd_d     = shd_q;
        act_tag_d = act_tag_q;
        shd_tag_d = shd_tag_q;
        pending_d = pending_q;
        pix_d     = pix_q;
        cnt_d     = cnt_q;
        ovf_set   = 1'b0;
        xfer      = (state_q == SEND) && out_ready;
        last_xfer = xfer && (pix_q == LAST_PIX);

        // Every frame_done is captured somewhere, so the tag counter always advances.
        if (frame_done) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    state_d   = SEND;
                    act_d     = result;
                    act_tag_d = cnt_q;
                    pix_d     = '0;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    pix_d = '0;
                    if (pending_q) begin
                        act_d     = shd_q;
                        act_tag_d = shd_tag_q;
                        if (frame_done) begin
                            shd_d     = result;
                            shd_tag_d = cnt_q;
                        end else begin
                            pending_d = 1'b0;
                        end
                    end else if (frame_done) begin
                        act_d     = result;
                        act_tag_d = cnt_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        pix_d = pix_q + 8'd1;
                    end
                    if (frame_done) begin
                        shd_d     = result;
                        shd_tag_d = cnt_q;
                        pending_d = 1'b1;
                        ovf_set   = pending_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < PIXEL_NUM; k++) begin
            if (pix_q == 8'(k)) begin
                out_data = act_q[k*NP +: NP];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && (pix_q == LAST_PIX);
    assign out_pix   = pix_q;
    assign out_frame = act_tag_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_peak_result_serializer.sv
// tb/tb_peak_result_serializer.sv - table, directed and randomized checks of peak_result_serializer
module tb_peak_result_serializer;

    localparam int NPW = 16;
    localparam int PN  = 4;

    logic            clk = 1'b0;
    logic            res = 1'b0;
    logic            frame_done = 1'b0;
    logic [63:0]     result = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [NPW-1:0]  out_data;
    logic [7:0]      out_pix;
    logic [7:0]      out_frame;
    logic            out_last;
    logic            overflow;
    logic            clr_ovf = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    peak_result_serializer #(.NP(NPW), .PIXEL_NUM(PN)) dut (
        .clk        (clk),
        .res        (res),
        .frame_done (frame_done),
        .result     (result),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_pix    (out_pix),
        .out_frame  (out_frame),
        .out_last   (out_last),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    // Reference: an ordered list of frames still owed downstream; head is being sent.
    // At most one frame may wait behind the head; a newer arrival replaces it.
    typedef struct {
        logic [7:0]  tag;
        logic [63:0] d;
    } frame_t;

    frame_t     mq[$];
    int         m_idx = 0;
    logic [7:0] m_cnt = 8'd0;
    logic       m_ovf = 1'b0;

    typedef struct {
        logic        fd;
        logic        rdy;
        logic [63:0] r;
        logic        ev;
        logic [7:0]  epix;
        logic [15:0] edata;
        logic [7:0]  efr;
        logic        elast;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic fd, input logic rdy, input logic [63:0] r,
                                 input logic ev, input int pix, input int data,
                                 input int fr, input logic lst);
        vec_t v;
        v.fd = fd; v.rdy = rdy; v.r = r; v.ev = ev;
        v.epix = 8'(pix); v.edata = 16'(data); v.efr = 8'(fr); v.elast = lst;
        return v;
    endfunction

    task automatic model_update(input logic fd, input logic rdy, input logic clr, input logic [63:0] r);
        logic   setf;
        frame_t f;
        setf = 1'b0;
        if (mq.size() > 0 && rdy) begin
            m_idx++;
            if (m_idx == PN) begin
                void'(mq.pop_front());
                m_idx = 0;
            end
        end
        if (fd) begin
            f.tag = m_cnt;
            f.d   = r;
            m_cnt = m_cnt + 8'd1;
            if (mq.size() >= 2) begin
                mq[1] = f;
                setf  = 1'b1;
            end else begin
                mq.push_back(f);
            end
        end
        if (clr) m_ovf = 1'b0;
        else if (setf) m_ovf = 1'b1;
    endtask

    task automatic model_check();
        logic [63:0] d;
        chk("m_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("m_overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() > 0) begin
            d = mq[0].d;
            chk("m_pix", 64'(out_pix), 64'(m_idx));
            chk("m_data", 64'(out_data), 64'(16'(d >> (m_idx * NPW))));
            chk("m_frame", 64'(out_frame), 64'(mq[0].tag));
            chk("m_last", 64'(out_last), 64'(m_idx == PN - 1));
        end else begin
            chk("m_last_idle", 64'(out_last), 64'd0);
        end
    endtask

    // Called at a falling edge; applies inputs across the next rising edge.
    task automatic step(input logic fd, input logic rdy, input logic clr, input logic [63:0] r);
        frame_done = fd;
        out_ready  = rdy;
        clr_ovf    = clr;
        result     = r;
        model_update(fd, rdy, clr, r);
        @(posedge clk);
        @(negedge clk);
        model_check();
        frame_done = 1'b0;
        clr_ovf    = 1'b0;
    endtask

    task automatic do_reset();
        res        = 1'b0;
        frame_done = 1'b0;
        out_ready  = 1'b0;
        clr_ovf    = 1'b0;
        mq.delete();
        m_idx = 0;
        m_cnt = 8'd0;
        m_ovf = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pix", 64'(out_pix), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_frame", 64'(out_frame), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        res = 1'b1;
    endtask

    initial begin
        logic [63:0] fa, fb, fc;
        fa = {16'd40, 16'd30, 16'd20, 16'd10};
        fb = {16'd4, 16'd3, 16'd2, 16'd1};
        fc = {16'hC3, 16'hC2, 16'hC1, 16'hC0};

        tbl[0]  = mkv(1, 1, fa, 1, 0, 10, 0, 0);
        tbl[1]  = mkv(0, 1, fa, 1, 1, 20, 0, 0);
        tbl[2]  = mkv(0, 1, fa, 1, 2, 30, 0, 0);
        tbl[3]  = mkv(0, 1, fa, 1, 3, 40, 0, 1);
        tbl[4]  = mkv(0, 1, fa, 0, 0, 0, 0, 0);
        tbl[5]  = mkv(1, 0, fb, 1, 0, 1, 1, 0);
        tbl[6]  = mkv(0, 1, fb, 1, 1, 2, 1, 0);
        tbl[7]  = mkv(0, 0, fb, 1, 1, 2, 1, 0);
        tbl[8]  = mkv(0, 0, fb, 1, 1, 2, 1, 0);
        tbl[9]  = mkv(0, 1, fb, 1, 2, 3, 1, 0);
        tbl[10] = mkv(0, 0, fb, 1, 2, 3, 1, 0);
        tbl[11] = mkv(0, 0, fb, 1, 2, 3, 1, 0);
        tbl[12] = mkv(0, 1, fb, 1, 3, 4, 1, 1);
        tbl[13] = mkv(0, 0, fb, 1, 3, 4, 1, 1);
        tbl[14] = mkv(0, 1, fb, 0, 0, 0, 0, 0);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].fd, tbl[i].rdy, 1'b0, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].elast));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pix", i), 64'(out_pix), 64'(tbl[i].epix));
                chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].edata));
                chk($sformatf("tbl%0d_frame", i), 64'(out_frame), 64'(tbl[i].efr));
            end
        end

        // Second frame arrives mid-transfer: no bubble between frames.
        do_reset();
        step(1, 1, 0, fa);
        step(1, 1, 0, fb);
        step(0, 1, 0, fb);
        step(0, 1, 0, fb);
        chk("dbl_pix3", 64'(out_pix), 64'd3);
        step(0, 1, 0, fb);
        chk("dbl_valid", 64'(out_valid), 64'd1);
        chk("dbl_pix0", 64'(out_pix), 64'd0);
        chk("dbl_frame", 64'(out_frame), 64'd1);
        chk("dbl_data", 64'(out_data), 64'd1);
        chk("dbl_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, fb);
        chk("dbl_idle", 64'(out_valid), 64'd0);

        // Three frames while stalled: frame 1 is dropped.
        do_reset();
        step(1, 0, 0, fa);
        step(1, 0, 0, fb);
        chk("ovf_before", 64'(overflow), 64'd0);
        step(1, 0, 0, fc);
        chk("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, fc);
        chk("ovf_frame", 64'(out_frame), 64'd2);
        chk("ovf_pix0", 64'(out_pix), 64'd0);
        chk("ovf_data", 64'(out_data), 64'hC0);
        step(0, 0, 1, fc);
        chk("ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, fc);

        // frame_done exactly on the last-beat transfer with nothing pending.
        do_reset();
        step(1, 1, 0, fa);
        step(0, 1, 0, fa);
        step(0, 1, 0, fa);
        step(0, 1, 0, fa);
        chk("coin_last", 64'(out_last), 64'd1);
        step(1, 1, 0, fb);
        chk("coin_valid", 64'(out_valid), 64'd1);
        chk("coin_pix0", 64'(out_pix), 64'd0);
        chk("coin_frame", 64'(out_frame), 64'd1);
        chk("coin_data", 64'(out_data), 64'd1);
        chk("coin_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, fb);

        // Reset while pixel 2 is on the bus.
        do_reset();
        step(1, 0, 0, fa);
        step(0, 1, 0, fa);
        step(0, 1, 0, fa);
        chk("rmid_pix2", 64'(out_pix), 64'd2);
        do_reset();
        step(1, 1, 0, fb);
        chk("rmid_valid", 64'(out_valid), 64'd1);
        chk("rmid_frame", 64'(out_frame), 64'd0);
        chk("rmid_pix", 64'(out_pix), 64'd0);
        chk("rmid_data", 64'(out_data), 64'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/peak_result_serializer.md
PEAK_RESULT_SERIALIZER -- requirements
Module: peak_result_serializer

Interface
REQ-001 SHALL have parameter NP, default 16: width of one per-pixel peak result in bits.
REQ-002 SHALL have parameter PIXEL_NUM, default 4: number of pixels per RAM, with 1 <= PIXEL_NUM <= 256.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port res  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_done  input  1: one-cycle pulse meaning the result bus holds a completed frame.
REQ-006 SHALL have port result  input  NP*PIXEL_NUM: packed peak results; pixel k occupies bits [k*NP +: NP].
REQ-007 SHALL have port out_ready  input  1: downstream accepts a beat.
REQ-008 SHALL have port out_valid  output  1: a beat is presented.
REQ-009 SHALL have port out_data  output  NP: peak result of the current pixel.
REQ-010 SHALL have port out_pix  output  8: index of the current pixel.
REQ-011 SHALL have port out_frame  output  8: frame tag of the current beat.
REQ-012 SHALL have port out_last  output  1: the current beat is pixel PIXEL_NUM-1.
REQ-013 SHALL have port overflow  output  1: sticky flag, a pending frame was overwritten.
REQ-014 SHALL have port clr_ovf  input  1: synchronous clear of overflow.

Function
REQ-015 SHALL implement two states, IDLE and SEND, with an active buffer, a shadow buffer and a pending bit.
REQ-016 SHALL, on frame_done in IDLE, load result into the active buffer, enter SEND, and assert out_valid with out_pix=0 on the next cycle (latency 1).
REQ-017 SHALL complete a transfer when out_valid=1 and out_ready=1; out_pix SHALL then advance by 1 on the next cycle.
REQ-018 SHALL hold out_data, out_pix, out_frame and out_last stable while out_valid=1 and out_ready=0.
REQ-019 SHALL drive out_data from active-buffer slice out_pix; out_last=1 iff out_pix==PIXEL_NUM-1 and out_valid=1.
REQ-020 SHALL, on frame_done in SEND without a last-beat transfer, load result into the shadow buffer and set pending=1.
REQ-021 SHALL, on frame_done in SEND while pending=1 and no last-beat transfer, overwrite the shadow buffer and set overflow=1.
REQ-022 SHALL, on a last-beat transfer with pending=1, copy shadow to active, clear pending (unless REQ-024 applies), stay in SEND and present pixel 0 of the new frame on the next cycle with no bubble.
REQ-023 SHALL, on a last-beat transfer with pending=0 and no frame_done, return to IDLE with out_valid=0 on the next cycle.
REQ-024 SHALL, when frame_done coincides with a last-beat transfer: if pending=0, load result directly into active and continue SEND from pixel 0; if pending=1, load shadow into active, load result into shadow, keep pending=1, and not set overflow.
REQ-025 SHALL increment an 8-bit frame counter on every captured frame_done, including overwritten frames, wrapping 255 to 0; each captured frame SHALL carry the counter value at capture, so dropped frames appear as gaps in out_frame.
REQ-026 SHALL give clr_ovf priority over setting overflow in the same cycle.
REQ-027 SHALL ignore out_ready while out_valid=0.

Reset
REQ-028 SHALL, on res low, asynchronously force IDLE, pending=0, out_valid=0, out_pix=0, out_data=0, out_frame=0, out_last=0, overflow=0, frame counter=0, and both buffers to 0.
REQ-029 SHALL discard any in-flight frame on reset mid-SEND, and SHALL give frame 0 to the first frame_done after reset release.

Verification
REQ-030 SHALL be checked for basic readout: reset, then frame_done with result={40,30,20,10} and out_ready=1 -> beats (pix,data) = (0,10),(1,20),(2,30),(3,40) on consecutive cycles starting 1 cycle after the pulse, out_last only on pix 3, out_frame=0, then out_valid=0.
REQ-031 SHALL be checked for back-pressure: out_ready toggled 1,0,0,1,... -> each beat is held unchanged while ready=0, and no beat is lost or duplicated.
REQ-032 SHALL be checked for double buffering: a second frame_done during SEND with out_ready=1 -> after pix 3 of frame 0, pix 0 of frame 1 appears on the very next cycle, and overflow=0.
REQ-033 SHALL be checked for overflow: three frame_done pulses while out_ready=0 -> overflow=1, the next frame sent after frame 0 has out_frame=2, and clr_ovf clears overflow.
REQ-034 SHALL be checked for coincidence: frame_done on the same cycle as the last-beat transfer with pending=0 -> the next cycle shows pix 0 of the new frame, and overflow=0.
REQ-035 SHALL be checked for reset mid-frame: res pulsed low at pix 2 -> out_valid=0 immediately, and the next frame_done yields out_frame=0 starting at pix 0.
